// File: rtl/ib_lut_ram_loader.sv
// ib_lut_ram_loader
// Streams one LUT frame, page by page, into the IB-CNU RAM banks.
// A load is requested in IDLE with load_start/load_frame. Each accepted beat
// of lut_word_in is written one cycle later to address {frame, page}. After
// PAGE_NUM pages the loader spends one DONE cycle, then marks the frame valid.
//
// Handshake: a beat transfers on a write_clk rising edge when lut_valid_in
// and lut_ready_out are both 1. lut_ready_out is high only in LOAD and is
// dropped combinationally by load_abort. The producer may hold lut_word_in
// for any number of cycles; nothing is taken while ready is low.
//
// Ports
//   write_clk      clock, all state on rising edge
//   rst            asynchronous active-high reset
//   load_start     start request (IDLE only); load_frame latched with it
//   load_abort     abandons a load in progress (LOAD only)
//   lut_word_in    one page of data; upper LUT_PORT_SIZE bits = bank0
//   lut_valid_in   lut_word_in valid
//   lut_ready_out  beat accepted this cycle when valid is also high
//   page_addr_ram  RAM write address {frame, page}
//   ram_write_data RAM write data
//   ib_ram_we      RAM write enable
//   load_busy      high in LOAD and DONE
//   load_done      one-cycle pulse on completion (coincides with last write)
//   frame_valid    per-frame "holds a complete LUT" flags
//   state_dbg      current FSM state, for observation only
module ib_lut_ram_loader #(
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int BANK_NUM        = 2,
  parameter int LUT_PORT_SIZE   = 2
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              load_frame,
  input  logic                              load_abort,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_word_in,
  input  logic                              lut_valid_in,
  output logic                              lut_ready_out,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
  output logic                              ib_ram_we,
  output logic                              load_busy,
  output logic                              load_done,
  output logic [MULTI_FRAME_NUM-1:0]        frame_valid,
  output logic [1:0]                        state_dbg
);

  localparam int PAGE_W   = ENTRY_ADDR - 1;
  localparam int PAGE_NUM = 1 << PAGE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PAGE_W-1:0] page_cnt;
  logic              frame;

  // Abort has priority over a simultaneous beat: ready drops, nothing transfers.
  assign lut_ready_out = (state == LOAD) && !load_abort;
  assign state_dbg     = state;

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      page_cnt       <= '0;
      frame          <= 1'b0;
      page_addr_ram  <= '0;
      ram_write_data <= '0;
      ib_ram_we      <= 1'b0;
      load_busy      <= 1'b0;
      load_done      <= 1'b0;
      frame_valid    <= '0;
    end else begin
      // Write enable and done are single-cycle strobes; address/data hold.
      ib_ram_we <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            frame                   <= load_frame;
            page_cnt                <= '0;
            frame_valid[load_frame] <= 1'b0;
            load_busy               <= 1'b1;
            state                   <= LOAD;
          end
        end
        LOAD: begin
          if (load_abort) begin
            page_cnt  <= '0;
            load_busy <= 1'b0;
            state     <= IDLE;
          end else if (lut_valid_in) begin
            page_addr_ram  <= {frame, page_cnt};
            ram_write_data <= lut_word_in;
            ib_ram_we      <= 1'b1;
            // Natural wrap of the PAGE_W-bit counter returns it to page 0.
            page_cnt       <= page_cnt + 1'b1;
            if (page_cnt == PAGE_W'(PAGE_NUM - 1)) begin
              load_done <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          frame_valid[frame] <= 1'b1;
          load_busy          <= 1'b0;
          state              <= IDLE;
        end
        default: begin
          load_busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ib_lut_ram_loader.sv
// Testbench for ib_lut_ram_loader. Expected RAM writes come from a simple
// model: every beat the driver presents while a load is running (and not
// aborted) becomes one write to {frame, beat_index}, queued in exp_q and
// matched in order by the write monitor.
module tb_ib_lut_ram_loader;

  localparam int AW = 4;
  localparam int NF = 2;
  localparam int DW = 4;
  localparam int PAGES = 8;

  logic          write_clk;
  logic          rst;
  logic          load_start;
  logic          load_frame;
  logic          load_abort;
  logic [DW-1:0] lut_word_in;
  logic          lut_valid_in;
  logic          lut_ready_out;
  logic [AW-1:0] page_addr_ram;
  logic [DW-1:0] ram_write_data;
  logic          ib_ram_we;
  logic          load_busy;
  logic          load_done;
  logic [NF-1:0] frame_valid;
  logic [1:0]    state_dbg;

  ib_lut_ram_loader #(
    .ENTRY_ADDR(AW), .MULTI_FRAME_NUM(NF), .BANK_NUM(2), .LUT_PORT_SIZE(2)
  ) dut (
    .write_clk(write_clk), .rst(rst), .load_start(load_start),
    .load_frame(load_frame), .load_abort(load_abort), .lut_word_in(lut_word_in),
    .lut_valid_in(lut_valid_in), .lut_ready_out(lut_ready_out),
    .page_addr_ram(page_addr_ram), .ram_write_data(ram_write_data),
    .ib_ram_we(ib_ram_we), .load_busy(load_busy), .load_done(load_done),
    .frame_valid(frame_valid), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] last_exp;
  logic [NF-1:0]    fv_exp;
  int checks;
  int errors;
  int n_writes;
  int we_run;

  // Write monitor: every write must match the next expected one; between
  // writes address/data must hold the last written values.
  always @(negedge write_clk) begin
    if (!rst) begin
      if (ib_ram_we === 1'b1) begin
        n_writes++;
        we_run++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h (no write expected)", page_addr_ram, ram_write_data);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          if ({page_addr_ram, ram_write_data} !== e) begin
            errors++;
            $display("FAIL write addr/data=%h/%h expected %h/%h", page_addr_ram, ram_write_data, e[AW+DW-1:DW], e[DW-1:0]);
          end
          last_exp = e;
        end
      end else begin
        we_run = 0;
        checks++;
        if ({page_addr_ram, ram_write_data} !== last_exp) begin
          errors++;
          $display("FAIL hold addr/data=%h/%h expected %h/%h", page_addr_ram, ram_write_data, last_exp[AW+DW-1:DW], last_exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({lut_ready_out, page_addr_ram, ram_write_data, ib_ram_we, load_busy, load_done, frame_valid} !== '0) begin
      errors++;
      $display("FAIL %s outputs ready=%b addr=%h data=%h we=%b busy=%b done=%b fv=%b expected all 0",
               tag, lut_ready_out, page_addr_ram, ram_write_data, ib_ram_we, load_busy, load_done, frame_valid);
    end
  endtask

  // Runs one load. Called and returns at 1 ns after a rising edge with the
  // loader idle, so consecutive calls issue load_start back to back.
  // mode: 0 full rate, 1 valid alternating 1,0, 2 random valid.
  // abort_at / start_at / rst_at: beat index at which to inject, -1 = never.
  task automatic do_load(input int f, input int mode, input bit seq_data,
                         input int abort_at, input int start_at, input int rst_at);
    int k;
    int cyc;
    int w0;
    bit v;
    w0 = n_writes;
    load_start = 1'b1;
    load_frame = f[0];
    step();
    load_start = 1'b0;
    load_frame = 1'b0;
    fv_exp[f] = 1'b0;
    k = 0;
    cyc = 0;
    while (k < PAGES) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      lut_valid_in = v;
      lut_word_in = seq_data ? k[DW-1:0] : DW'($urandom_range(0, 15));
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_load");
        exp_q.delete();
        last_exp = '0;
        fv_exp = '0;
        lut_valid_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        return;
      end
      if (k == abort_at) begin
        load_abort = 1'b1;
        lut_valid_in = 1'b1;
        #0;
        checks++;
        if (lut_ready_out !== 1'b0) begin
          errors++;
          $display("FAIL abort_ready ready=%b expected 0", lut_ready_out);
        end
        step();
        load_abort = 1'b0;
        lut_valid_in = 1'b0;
        checks++;
        if ({load_busy, load_done, frame_valid} !== {1'b0, 1'b0, fv_exp}) begin
          errors++;
          $display("FAIL abort_exit busy=%b done=%b fv=%b expected 0 0 %b", load_busy, load_done, frame_valid, fv_exp);
        end
        step();
        step();
        checks++;
        if (n_writes - w0 != abort_at) begin
          errors++;
          $display("FAIL abort_writes count=%0d expected %0d", n_writes - w0, abort_at);
        end
        return;
      end
      if (k == start_at) begin
        load_start = 1'b1;
        load_frame = ~f[0];
      end
      #0;
      checks++;
      if ({lut_ready_out, load_busy, load_done, frame_valid} !== {1'b1, 1'b1, 1'b0, fv_exp}) begin
        errors++;
        $display("FAIL load_cycle ready=%b busy=%b done=%b fv=%b expected 1 1 0 %b",
                 lut_ready_out, load_busy, load_done, frame_valid, fv_exp);
      end
      if (v) exp_q.push_back({f[0], k[AW-2:0], lut_word_in});
      step();
      load_start = 1'b0;
      load_frame = 1'b0;
      if (v) k++;
      cyc++;
    end
    lut_valid_in = 1'b0;
    // DONE cycle: last write and done pulse together.
    checks++;
    if ({load_done, load_busy, ib_ram_we, frame_valid} !== {1'b1, 1'b1, 1'b1, fv_exp}) begin
      errors++;
      $display("FAIL done_cycle done=%b busy=%b we=%b fv=%b expected 1 1 1 %b",
               load_done, load_busy, ib_ram_we, frame_valid, fv_exp);
    end
    step();
    fv_exp[f] = 1'b1;
    checks++;
    if ({load_done, load_busy, frame_valid} !== {1'b0, 1'b0, fv_exp}) begin
      errors++;
      $display("FAIL after_done done=%b busy=%b fv=%b expected 0 0 %b", load_done, load_busy, frame_valid, fv_exp);
    end
    checks++;
    if (n_writes - w0 != PAGES) begin
      errors++;
      $display("FAIL write_count count=%0d expected %0d", n_writes - w0, PAGES);
    end
    if (mode == 0) begin
      checks++;
      if (we_run != PAGES) begin
        errors++;
        $display("FAIL full_rate_run consecutive_we=%0d expected %0d", we_run, PAGES);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_all_zero("after_reset");
  endtask

  task automatic test_idle_ignores();
    lut_valid_in = 1'b1;
    load_abort = 1'b1;
    lut_word_in = 4'hA;
    #0;
    checks++;
    if ({lut_ready_out, load_busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_ready ready=%b busy=%b expected 0 0", lut_ready_out, load_busy);
    end
    step();
    step();
    lut_valid_in = 1'b0;
    load_abort = 1'b0;
    checks++;
    if ({load_busy, frame_valid} !== {1'b0, fv_exp}) begin
      errors++;
      $display("FAIL idle_stay busy=%b fv=%b expected 0 %b", load_busy, frame_valid, fv_exp);
    end
  endtask

  task automatic test_full_rate();      do_load(1, 0, 1'b1, -1, -1, -1); endtask
  task automatic test_gaps();           do_load(0, 1, 1'b0, -1, -1, -1); endtask
  task automatic test_abort();          do_load(0, 0, 1'b0,  3, -1, -1); endtask
  task automatic test_start_ignored();  do_load(0, 0, 1'b0, -1,  4, -1); endtask

  task automatic test_rst_mid_load();
    do_load(0, 0, 1'b0, -1, -1, 5);
    do_load(0, 0, 1'b1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_load(0, 0, 1'b0, -1, -1, -1);
    do_load(1, 0, 1'b0, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_load(int'($urandom_range(0, 1)), 2, 1'b0, -1, -1, -1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
    end
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    load_frame = 1'b0;
    load_abort = 1'b0;
    lut_word_in = '0;
    lut_valid_in = 1'b0;
    last_exp = '0;
    fv_exp = '0;
    checks = 0;
    errors = 0;
    n_writes = 0;
    we_run = 0;

    test_reset();
    test_idle_ignores();
    test_full_rate();
    test_gaps();
    test_abort();
    test_start_ignored();
    test_rst_mid_load();
    test_back_to_back();
    test_random();
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes pending=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
